// File: rtl/input_repeat_gen_pkg.sv
// Shared constants and state types for the held-key to command-pulse converter.
package input_repeat_gen_pkg;

  localparam int unsigned DasFramesDef = 10;
  localparam int unsigned ArrFramesDef = 2;
  localparam int unsigned SdrFramesDef = 2;
  localparam int unsigned CntWDef      = 6;

  // Bit positions of the key/command vectors used inside the top.
  localparam int unsigned NumKeys   = 7;
  localparam int unsigned IdxLeft   = 0;
  localparam int unsigned IdxRight  = 1;
  localparam int unsigned IdxDown   = 2;
  localparam int unsigned IdxRotCw  = 3;
  localparam int unsigned IdxRotCcw = 4;
  localparam int unsigned IdxDrop   = 5;
  localparam int unsigned IdxHold   = 6;

  typedef enum logic [1:0] {HIdle, HDelay, HRepeat} h_state_t;
  typedef enum logic {DIdle, DRepeat} d_state_t;
  typedef enum logic {DirLeft, DirRight} dir_t;

endpackage

// File: rtl/input_repeat_gen_repeat_timer.sv
// Frame counter: counts ticks and fires on the tick that completes period_i frames.
module input_repeat_gen_repeat_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             restart_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             fire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Not gated by restart_i so the caller can use fire_o without a comb loop.
  assign fire_o = tick_i & (cnt_q == (period_i - CNT_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = fire_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/input_repeat_gen.sv
// Turns held key levels into one-cycle game commands with DAS/ARR horizontal
// auto-repeat, soft-drop repeat and one-shot rotate/drop/hold.
module input_repeat_gen
  import input_repeat_gen_pkg::*;
#(
  parameter int unsigned DAS_FRAMES = DasFramesDef,
  parameter int unsigned ARR_FRAMES = ArrFramesDef,
  parameter int unsigned SDR_FRAMES = SdrFramesDef,
  parameter int unsigned CNT_W      = CntWDef
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic tick_game,
  input  logic raw_left,
  input  logic raw_right,
  input  logic raw_down,
  input  logic raw_rotate_cw,
  input  logic raw_rotate_ccw,
  input  logic raw_drop,
  input  logic raw_hold,
  output logic cmd_left,
  output logic cmd_right,
  output logic cmd_down,
  output logic cmd_rotate_cw,
  output logic cmd_rotate_ccw,
  output logic cmd_drop,
  output logic cmd_hold
);

  logic [NumKeys-1:0] raw, rise, prev_q, prev_d, cmd_q, cmd_d;
  h_state_t           h_state_q, h_state_d;
  d_state_t           d_state_q, d_state_d;
  dir_t               dir_q, dir_d;
  logic               h_restart, h_fire, h_left, h_right;
  logic               d_restart, d_fire, d_pulse;
  logic               act_held, oth_held, oth_rise;
  logic [CNT_W-1:0]   h_period;

  assign raw  = {raw_hold, raw_drop, raw_rotate_ccw, raw_rotate_cw, raw_down, raw_right, raw_left};
  assign rise = raw & ~prev_q;

  assign h_period = (h_state_q == HRepeat) ? CNT_W'(ARR_FRAMES) : CNT_W'(DAS_FRAMES);

  input_repeat_gen_repeat_timer #(
    .CNT_W(CNT_W)
  ) u_h_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .restart_i(h_restart),
    .tick_i   (tick_game),
    .period_i (h_period),
    .fire_o   (h_fire)
  );

  input_repeat_gen_repeat_timer #(
    .CNT_W(CNT_W)
  ) u_d_timer (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .restart_i(d_restart),
    .tick_i   (tick_game),
    .period_i (CNT_W'(SDR_FRAMES)),
    .fire_o   (d_fire)
  );

  // Horizontal channel: last pressed direction wins, release falls back to the other key.
  always_comb begin
    h_state_d = h_state_q;
    dir_d     = dir_q;
    h_restart = 1'b0;
    h_left    = 1'b0;
    h_right   = 1'b0;
    act_held  = (dir_q == DirLeft) ? raw[IdxLeft] : raw[IdxRight];
    oth_held  = (dir_q == DirLeft) ? raw[IdxRight] : raw[IdxLeft];
    oth_rise  = (dir_q == DirLeft) ? rise[IdxRight] : rise[IdxLeft];
    if (!enable) begin
      h_state_d = HIdle;
      h_restart = 1'b1;
    end else begin
      case (h_state_q)
        HIdle: begin
          h_restart = 1'b1;
          if (rise[IdxLeft]) begin
            dir_d     = DirLeft;
            h_left    = 1'b1;
            h_state_d = HDelay;
          end else if (rise[IdxRight]) begin
            dir_d     = DirRight;
            h_right   = 1'b1;
            h_state_d = HDelay;
          end
        end
        HDelay, HRepeat: begin
          if (oth_rise || (!act_held && oth_held)) begin
            dir_d     = (dir_q == DirLeft) ? DirRight : DirLeft;
            h_left    = (dir_q == DirRight);
            h_right   = (dir_q == DirLeft);
            h_restart = 1'b1;
            h_state_d = HDelay;
          end else if (!act_held) begin
            h_restart = 1'b1;
            h_state_d = HIdle;
          end else if (h_fire) begin
            h_left    = (dir_q == DirLeft);
            h_right   = (dir_q == DirRight);
            h_state_d = HRepeat;
          end
        end
        default: begin
          h_restart = 1'b1;
          h_state_d = HIdle;
        end
      endcase
    end
  end

  always_comb begin
    d_state_d = d_state_q;
    d_restart = 1'b0;
    d_pulse   = 1'b0;
    if (!enable) begin
      d_state_d = DIdle;
      d_restart = 1'b1;
    end else begin
      case (d_state_q)
        DIdle: begin
          d_restart = 1'b1;
          if (rise[IdxDown]) begin
            d_pulse   = 1'b1;
            d_state_d = DRepeat;
          end
        end
        DRepeat: begin
          if (!raw[IdxDown]) begin
            d_restart = 1'b1;
            d_state_d = DIdle;
          end else if (d_fire) begin
            d_pulse = 1'b1;
          end
        end
        default: begin
          d_restart = 1'b1;
          d_state_d = DIdle;
        end
      endcase
    end
  end

  always_comb begin
    prev_d = raw;
    cmd_d  = '0;
    if (enable) begin
      cmd_d[IdxLeft]   = h_left;
      cmd_d[IdxRight]  = h_right;
      cmd_d[IdxDown]   = d_pulse;
      cmd_d[IdxRotCw]  = rise[IdxRotCw];
      cmd_d[IdxRotCcw] = rise[IdxRotCcw] & ~rise[IdxRotCw];
      cmd_d[IdxDrop]   = rise[IdxDrop];
      cmd_d[IdxHold]   = rise[IdxHold];
    end
  end

  // prev resets high so keys held through reset never look like a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '1;
      cmd_q     <= '0;
      h_state_q <= HIdle;
      d_state_q <= DIdle;
      dir_q     <= DirLeft;
    end else begin
      prev_q    <= prev_d;
      cmd_q     <= cmd_d;
      h_state_q <= h_state_d;
      d_state_q <= d_state_d;
      dir_q     <= dir_d;
    end
  end

  assign cmd_left       = cmd_q[IdxLeft];
  assign cmd_right      = cmd_q[IdxRight];
  assign cmd_down       = cmd_q[IdxDown];
  assign cmd_rotate_cw  = cmd_q[IdxRotCw];
  assign cmd_rotate_ccw = cmd_q[IdxRotCcw];
  assign cmd_drop       = cmd_q[IdxDrop];
  assign cmd_hold       = cmd_q[IdxHold];

endmodule
